div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the MIPS pipeline, serving DIV and DIVU issued from the execute stage. EX asserts a start request with two operands and holds it, along with its stall request, until this block returns a 64-bit {remainder, quotient} result with a ready flag. EX then writes the result into HI/LO through the usual hi_o/lo_o/whilo_o path. The block uses a radix-2 restoring algorithm: one quotient bit per clock, 32 iterations.

---
 rtl/div_unit_if.sv | 31 +++
 rtl/div_unit.sv | 128 ++++++++++++
 tb/tb_div_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// EX drives the operands and start/annul; the divider returns {remainder, quotient} with ready.
interface div_unit_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU: one quotient bit per clock, 32 steps,
// signs stripped on entry and reapplied at the end; result held until EX drops start.
module div_unit (
    input  logic       clk,
    input  logic       clr,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [64:0] dividend_reg, dividend_next;
    logic [31:0] divisor_reg, divisor_next;
    logic        q_neg_reg, q_neg_next;
    logic        r_neg_reg, r_neg_next;
    logic [63:0] result_reg, result_next;
    logic        ready_reg, ready_next;

    logic [31:0] abs_op1, abs_op2;
    logic [32:0] diff;
    logic [31:0] quot_fixed, rem_fixed;

    // Magnitudes are only taken for signed requests; unsigned operands pass through.
    assign abs_op1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    assign abs_op2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

    // Partial remainder lives in dividend[64:33] once all steps are done; quotient in [31:0].
    assign diff       = {1'b0, dividend_reg[63:32]} - {1'b0, divisor_reg};
    assign quot_fixed = q_neg_reg ? (~dividend_reg[31:0] + 32'd1) : dividend_reg[31:0];
    assign rem_fixed  = r_neg_reg ? (~dividend_reg[64:33] + 32'd1) : dividend_reg[64:33];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg    <= FREE;
            cnt_reg      <= 6'd0;
            dividend_reg <= 65'd0;
            divisor_reg  <= 32'd0;
            q_neg_reg    <= 1'b0;
            r_neg_reg    <= 1'b0;
            result_reg   <= 64'd0;
            ready_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            q_neg_reg    <= q_neg_next;
            r_neg_reg    <= r_neg_next;
            result_reg   <= result_next;
            ready_reg    <= ready_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        q_neg_next    = q_neg_reg;
        r_neg_next    = r_neg_reg;
        result_next   = result_reg;
        ready_next    = ready_reg;

        case (state_reg)
            FREE: begin
                ready_next  = 1'b0;
                result_next = 64'd0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == 32'd0) begin
                        state_next = BYZERO;
                    end else begin
                        state_next    = ON;
                        cnt_next      = 6'd0;
                        dividend_next = {32'd0, abs_op1, 1'b0};
                        divisor_next  = abs_op2;
                        q_neg_next    = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                        r_neg_next    = bus.signed_div_i & bus.opdata1_i[31];
                    end
                end
            end
            BYZERO: begin
                result_next = 64'd0;
                if (bus.annul_i) begin
                    state_next = FREE;
                    ready_next = 1'b0;
                end else begin
                    state_next = END;
                    ready_next = 1'b1;
                end
            end
            ON: begin
                if (bus.annul_i) begin
                    state_next  = FREE;
                    cnt_next    = 6'd0;
                    ready_next  = 1'b0;
                    result_next = 64'd0;
                end else if (cnt_reg != 6'd32) begin
                    // Restore by simply not committing the subtraction when it borrows.
                    if (diff[32])
                        dividend_next = {dividend_reg[63:0], 1'b0};
                    else
                        dividend_next = {diff[31:0], dividend_reg[31:0], 1'b1};
                    cnt_next = cnt_reg + 6'd1;
                end else begin
                    state_next  = END;
                    cnt_next    = 6'd0;
                    result_next = {rem_fixed, quot_fixed};
                    ready_next  = 1'b1;
                end
            end
            END: begin
                if (!bus.start_i || bus.annul_i) begin
                    state_next  = FREE;
                    ready_next  = 1'b0;
                    result_next = 64'd0;
                end
            end
            default: begin
                state_next  = FREE;
                ready_next  = 1'b0;
                result_next = 64'd0;
            end
        endcase
    end

    assign bus.result_o = result_reg;
    assign bus.ready_o  = ready_reg;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: directed corner cases plus random DIV/DIVU traffic,
// checked against a plain-arithmetic reference and the expected request-to-ready latency.
module tb_div_unit;
    logic clk;
    logic clr;
    div_unit_if bus();

    div_unit u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycle_cnt = 0;
    int txn_cnt   = 0;

    logic [63:0] sb_res[$];
    int          sb_lat[$];
    int          sb_t0[$];

    always @(posedge clk) cycle_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: sign-magnitude arithmetic in 64-bit integers, truncated to 32 bits per half.
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            ma = longint'($signed(a));
            mb = longint'($signed(b));
        end else begin
            ma = longint'({32'd0, a});
            mb = longint'({32'd0, b});
        end
        q = ma / mb;
        r = ma % mb;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: one scoreboard pop per rising ready_o.
    bit ready_seen = 1'b0;
    always @(negedge clk) begin
        if (bus.ready_o && !ready_seen) begin
            if (sb_res.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                int lat, t0;
                e   = sb_res.pop_front();
                lat = sb_lat.pop_front();
                t0  = sb_t0.pop_front();
                txn_cnt++;
                $display("txn %0d: result %h expected %h latency %0d", txn_cnt, bus.result_o, e, cycle_cnt - t0);
                check("result", bus.result_o, e);
                check("latency", 64'(cycle_cnt - t0), 64'(lat));
            end
        end
        ready_seen = bus.ready_o;
    end

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        sb_res.push_back(exp);
        sb_lat.push_back((b == 32'd0) ? 2 : 34);
        sb_t0.push_back(cycle_cnt);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("ready_timeout", 64'd0, 64'd1);
            if (sb_res.size() != 0) begin
                void'(sb_res.pop_front());
                void'(sb_lat.pop_front());
                void'(sb_t0.pop_front());
            end
        end
    endtask

    task automatic complete(input logic [63:0] exp);
        bit ok;
        @(posedge clk);
        #1;
        // Operands wander after acceptance; the divider must ignore them.
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom_range(0, 1));
        wait_ready(ok);
        if (ok) begin
            @(negedge clk);
            @(negedge clk);
            check("hold_result", bus.result_o, exp);
            check("hold_ready", 64'(bus.ready_o), 64'd1);
        end
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check("drop_ready", 64'(bus.ready_o), 64'd0);
        check("drop_result", bus.result_o, 64'd0);
    endtask

    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        @(negedge clk);
        issue(s, a, b, exp);
        complete(exp);
    endtask

    initial begin
        bit ok;
        int rises;
        bit s;
        logic [31:0] a, b;

        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        clr = 1'b1;
        #1;
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;

        run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
        run_op(1'b0, 32'h12345678, 32'd0, 64'd0);
        run_op(1'b1, 32'h12345678, 32'd0, 64'd0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run_op(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
        run_op(1'b0, 32'd5, 32'd9, 64'h00000005_00000000);

        // Annul partway through: nothing may come back.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'hFFFFFFFF;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (10) @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        rises = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o) rises++;
        end
        check("annul_no_ready", 64'(rises), 64'd0);
        run_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        // Annul and start together in FREE: the request must not be taken.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b1;
        repeat (3) @(negedge clk);
        check("annul_start_free", 64'(bus.ready_o), 64'd0);
        bus.annul_i = 1'b0;
        issue(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        complete(64'h00000002_0000000E);

        // Asynchronous clear mid-iteration, between edges.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (21) @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        check("clr_mid_on_ready", 64'(bus.ready_o), 64'd0);
        check("clr_mid_on_result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

        // Asynchronous clear while a result is being held.
        @(negedge clk);
        issue(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        wait_ready(ok);
        @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        check("clr_in_end_ready", 64'(bus.ready_o), 64'd0);
        check("clr_in_end_result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'd0 - 32'($urandom_range(1, 15));
                3:       b = 32'hFFFFFFFF;
                default: b = 32'($urandom);
            endcase
            run_op(s, a, b, model(s, a, b));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb_res.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
